// File: rtl/act_q15_pkg.sv
// act_q15_pkg: shared constants for the Q1.15 tanh/sigmoid activation unit
package act_q15_pkg;
  localparam logic [15:0] TANH_LUT [0:8] = '{
    16'd0, 16'd4075, 16'd8025, 16'd11743, 16'd15143,
    16'd18173, 16'd20813, 16'd23066, 16'd24956
  };
  localparam logic FUNC_TANH = 1'b0;
  localparam logic FUNC_SIGMOID = 1'b1;
  localparam logic signed [15:0] Q15_HALF = 16'sd16384;
endpackage

// File: rtl/act_pwl_core.sv
// act_pwl_core: combinational piecewise-linear tanh from sign, segment and fraction
// ACTQ15_ROUND_EN selects round-half-up interpolation instead of truncation.
module act_pwl_core
  import act_q15_pkg::*;
(
  input  logic               sign,
  input  logic [3:0]         k,
  input  logic [11:0]        f,
  output logic signed [15:0] r
);
`ifdef ACTQ15_ROUND_EN
  localparam logic [27:0] RND = 28'd2048;
`else
  localparam logic [27:0] RND = 28'd0;
`endif
  logic [3:0]  kc;
  logic [3:0]  kn;
  logic [15:0] dt;
  logic [15:0] term;
  logic [15:0] mag;
  logic [27:0] prod;
  // the last segment (k=8) has zero slope, so it collapses to T[8]
  always_comb begin
    kc   = (k > 4'd8) ? 4'd8 : k;
    kn   = (kc == 4'd8) ? kc : kc + 4'd1;
    dt   = TANH_LUT[kn] - TANH_LUT[kc];
    prod = 28'(dt) * 28'(f);
    term = 16'((prod + RND) >> 12);
    mag  = TANH_LUT[kc] + term;
    r    = sign ? -$signed(mag) : $signed(mag);
  end
endmodule

// File: rtl/activation_approx_q15.sv
// activation_approx_q15: 2-stage pipelined Q1.15 tanh/sigmoid, one sample per cycle
// Build with ACTQ15_ROUND_EN for rounded interpolation.
module activation_approx_q15
  import act_q15_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic               func_sel,
  input  logic signed [15:0] x,
  output logic               valid_out,
  output logic signed [15:0] y
);
  logic               v1_d, v1_q, func_d, func_q, sign_d, sign_q, vo_d, vo_q;
  logic [3:0]         k_d, k_q;
  logic [11:0]        f_d, f_q;
  logic [15:0]        mag;
  logic signed [15:0] op, r, y_d, y_q;
  // sigmoid(x) = 0.5 + tanh(x/2)/2, so the operand is halved before the core
  always_comb begin
    op     = (func_sel == FUNC_SIGMOID) ? (x >>> 1) : x;
    mag    = op[15] ? 16'(-op) : 16'(op);
    v1_d   = valid_in;
    func_d = func_sel;
    sign_d = op[15];
    k_d    = mag[15:12];
    f_d    = mag[11:0];
    vo_d   = v1_q;
    y_d    = !v1_q ? y_q : (func_q == FUNC_SIGMOID) ? Q15_HALF + (r >>> 1) : r;
  end
  act_pwl_core u_core (
    .sign (sign_q),
    .k    (k_q),
    .f    (f_q),
    .r    (r)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      func_q <= 1'b0;
      sign_q <= 1'b0;
      k_q    <= 4'd0;
      f_q    <= 12'd0;
      vo_q   <= 1'b0;
      y_q    <= 16'sd0;
    end else begin
      v1_q   <= v1_d;
      func_q <= func_d;
      sign_q <= sign_d;
      k_q    <= k_d;
      f_q    <= f_d;
      vo_q   <= vo_d;
      y_q    <= y_d;
    end
  end
  assign valid_out = vo_q;
  assign y         = y_q;
endmodule

// File: tb/tb_activation_approx_q15.sv
// tb_activation_approx_q15: randomized self-checking bench against an arithmetic tanh/sigmoid model
module tb_activation_approx_q15;
`ifdef ACTQ15_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif
  localparam int T [0:8] = '{0, 4075, 8025, 11743, 15143, 18173, 20813, 23066, 24956};
  localparam int N = 16384;
  logic               clk = 1'b0;
  logic               rst, valid_in, func_sel;
  logic signed [15:0] x;
  logic               valid_out;
  logic signed [15:0] y;
  int n_chk = 0;
  int n_fail = 0;
  int res [0:N-1];
  activation_approx_q15 dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .func_sel  (func_sel),
    .x         (x),
    .valid_out (valid_out),
    .y         (y)
  );
  always #5 clk = ~clk;
  function automatic int model(bit fs, int xv);
    int v, m, k, f, r;
    v = fs ? (xv >>> 1) : xv;
    m = (v < 0) ? -v : v;
    k = m / 4096;
    f = m % 4096;
    r = (k == 8) ? T[8] : T[k] + ((T[k+1] - T[k]) * f + (ROUND ? 2048 : 0)) / 4096;
    if (v < 0) r = -r;
    return fs ? 16384 + (r >>> 1) : r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b1; func_sel = 1'b0; x = 16'sd16384;
    tick(); tick();
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_vo got %b want 0", valid_out); end
    n_chk++; if (y !== 16'sd0) begin n_fail++; $display("FAIL reset_y got %0d want 0", y); end
    rst = 1'b0;
    tick();
    valid_in = 1'b0;
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL first_vo_early got %b want 0", valid_out); end
    tick();
    n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL first_vo got %b want 1", valid_out); end
    n_chk++; if (y !== 16'sd15143) begin n_fail++; $display("FAIL first_y got %0d want 15143", y); end
    tick();
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL first_vo_drop got %b want 0", valid_out); end
  endtask
  task automatic test_points();
    bit fs [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
    int xs [9] = '{0, 16384, -16384, -32768, 32767, 0, 32767, -32768, 4096};
    int ex [9];
    ex = '{0, 15143, -15143, -24956, ROUND ? 24956 : 24955, 16384, 23955, 8812, ROUND ? 17403 : 17402};
    for (int i = 0; i < 9; i++) begin
      valid_in = 1'b1; func_sel = fs[i]; x = 16'(xs[i]);
      tick();
      valid_in = 1'b0;
      n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL point%0d_vo_early got %b want 0", i, valid_out); end
      tick();
      n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL point%0d_vo got %b want 1", i, valid_out); end
      n_chk++; if (y !== 16'(ex[i])) begin n_fail++; $display("FAIL point%0d fs=%0d x=%0d got %0d want %0d", i, fs[i], xs[i], y, ex[i]); end
    end
  endtask
  task automatic test_sweep(bit fs);
    int xp;
    for (int i = 0; i <= N; i++) begin
      valid_in = (i < N); func_sel = fs; x = 16'(-32768 + 4 * i);
      tick();
      if (i >= 1) begin
        xp = -32768 + 4 * (i - 1);
        res[i-1] = int'(y);
        n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL sweep%0d_vo x=%0d got %b want 1", fs, xp, valid_out); end
        n_chk++; if (y !== 16'(model(fs, xp))) begin n_fail++; $display("FAIL sweep%0d x=%0d got %0d want %0d", fs, xp, y, model(fs, xp)); end
      end
    end
    valid_in = 1'b0;
    for (int j = 1; j < N; j++) begin
      n_chk++; if (res[j] < res[j-1]) begin n_fail++; $display("FAIL mono%0d x=%0d got %0d below prior %0d", fs, -32768 + 4 * j, res[j], res[j-1]); end
      if (!fs) begin
        n_chk++; if (res[j] != -res[N-j]) begin n_fail++; $display("FAIL odd x=%0d got %0d want %0d", -32768 + 4 * j, res[j], -res[N-j]); end
      end
    end
  endtask
  task automatic test_random();
    bit pv = 1'b0, have = 1'b0, cv, cf;
    int pe = 0, last = 0, cx;
    for (int i = 0; i < 3000; i++) begin
      cv = (i == 0) || ($urandom_range(0, 3) != 0);
      cf = 1'($urandom_range(0, 1));
      cx = $urandom_range(0, 65535) - 32768;
      valid_in = cv; func_sel = cf; x = 16'(cx);
      tick();
      n_chk++; if (valid_out !== pv) begin n_fail++; $display("FAIL rand_vo cycle %0d got %b want %b", i, valid_out, pv); end
      if (pv) begin last = pe; have = 1'b1; end
      if (have) begin
        n_chk++; if (y !== 16'(last)) begin n_fail++; $display("FAIL rand_y cycle %0d got %0d want %0d", i, y, last); end
      end
      pv = cv;
      pe = model(cf, cx);
    end
    valid_in = 1'b0;
    tick();
  endtask
  task automatic test_back_to_back();
    int xs [8];
    for (int i = 0; i < 8; i++) xs[i] = $urandom_range(0, 65535) - 32768;
    for (int i = 0; i <= 8; i++) begin
      valid_in = (i < 8); func_sel = (i % 2 == 1); x = 16'(xs[i % 8]);
      tick();
      if (i >= 1) begin
        n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_vo got %b want 1", i - 1, valid_out); end
        n_chk++; if (y !== 16'(model((i - 1) % 2 == 1, xs[i-1]))) begin n_fail++; $display("FAIL b2b%0d got %0d want %0d", i - 1, y, model((i - 1) % 2 == 1, xs[i-1])); end
      end
    end
    valid_in = 1'b0;
    tick();
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_end_vo got %b want 0", valid_out); end
  endtask
  task automatic test_bubble();
    int xa, xb, ea, eb;
    xa = $urandom_range(0, 65535) - 32768; ea = model(1'b0, xa);
    xb = $urandom_range(0, 65535) - 32768; eb = model(1'b1, xb);
    valid_in = 1'b1; func_sel = 1'b0; x = 16'(xa);
    tick();
    valid_in = 1'b0; x = 16'(xb);
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL bub_c0_vo got %b want 0", valid_out); end
    tick();
    n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL bub_c1_vo got %b want 1", valid_out); end
    n_chk++; if (y !== 16'(ea)) begin n_fail++; $display("FAIL bub_a got %0d want %0d", y, ea); end
    valid_in = 1'b1; func_sel = 1'b1; x = 16'(xb);
    tick();
    valid_in = 1'b0;
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL bub_c2_vo got %b want 0", valid_out); end
    n_chk++; if (y !== 16'(ea)) begin n_fail++; $display("FAIL bub_hold got %0d want %0d", y, ea); end
    tick();
    n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL bub_c3_vo got %b want 1", valid_out); end
    n_chk++; if (y !== 16'(eb)) begin n_fail++; $display("FAIL bub_b got %0d want %0d", y, eb); end
    tick();
  endtask
  task automatic test_reset_midstream();
    valid_in = 1'b1; func_sel = 1'b0; x = 16'sd16384;
    tick();
    func_sel = 1'b1; x = -16'sd20000;
    tick();
    n_chk++; if (y !== 16'sd15143 || valid_out !== 1'b1) begin n_fail++; $display("FAIL mid_pre got %0d/%b want 15143/1", y, valid_out); end
    rst = 1'b1;
    tick();
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_vo got %b want 0", valid_out); end
    n_chk++; if (y !== 16'sd0) begin n_fail++; $display("FAIL mid_rst_y got %0d want 0", y); end
    rst = 1'b0; valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (valid_out !== 1'b0 || y !== 16'sd0) begin n_fail++; $display("FAIL mid_stale cycle %0d got %0d/%b want 0/0", i, y, valid_out); end
    end
  endtask
  initial begin
    rst = 1'b1; valid_in = 1'b0; func_sel = 1'b0; x = 16'sd0;
    test_reset();
    test_points();
    test_sweep(1'b0);
    test_sweep(1'b1);
    test_random();
    test_back_to_back();
    test_bubble();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
